// File: rtl/line_draw_scheduler.sv
// Round-robin scheduler sharing one Bresenham line engine among NREQ requesters.
// Optional watchdog on the engine wait: define LINE_SCHED_TMO_EN.
module line_draw_scheduler #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned COORD_W = 8,
   parameter int unsigned TMO_CYC = 8192,
   localparam int unsigned ID_W   = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*COORD_W-1:0] req_x0,
   input  logic [NREQ*COORD_W-1:0] req_y0,
   input  logic [NREQ*COORD_W-1:0] req_x1,
   input  logic [NREQ*COORD_W-1:0] req_y1,
   output logic [NREQ-1:0]         ack,
   output logic [NREQ-1:0]         cmp,
   output logic                    cmp_err,
   output logic [COORD_W-1:0]      eng_x0,
   output logic [COORD_W-1:0]      eng_y0,
   output logic [COORD_W-1:0]      eng_x1,
   output logic [COORD_W-1:0]      eng_y1,
   output logic                    eng_start,
   input  logic                    eng_done,
   output logic                    busy,
   output logic [ID_W-1:0]         cur_id
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StRelease} state_e;

   localparam logic [ID_W:0]   NreqW = (ID_W+1)'(NREQ);
   localparam logic [NREQ-1:0] OneHot0 = NREQ'(1);

   state_e state_q, state_d;
   logic [ID_W-1:0] rr_q, rr_d, cur_q, cur_d, pick;
   logic [ID_W:0] scan;
   logic found, tmo_hit;
   logic [NREQ-1:0] ack_q, ack_d, cmp_q, cmp_d;
   logic err_q, err_d, start_q, start_d, busy_q, busy_d;
   logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
   logic [COORD_W-1:0] sel_x0, sel_y0, sel_x1, sel_y1;

   // First pending request at or above the round-robin pointer, wrapping mod NREQ.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      scan  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         scan = {1'b0, rr_q} + (ID_W+1)'(i);
         if (scan >= NreqW) scan = scan - NreqW;
         if (!found && req[scan[ID_W-1:0]]) begin
            found = 1'b1;
            pick  = scan[ID_W-1:0];
         end
      end
   end

   always_comb begin
      sel_x0 = '0;
      sel_y0 = '0;
      sel_x1 = '0;
      sel_y1 = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (pick == ID_W'(i)) begin
            sel_x0 = req_x0[i*COORD_W +: COORD_W];
            sel_y0 = req_y0[i*COORD_W +: COORD_W];
            sel_x1 = req_x1[i*COORD_W +: COORD_W];
            sel_y1 = req_y1[i*COORD_W +: COORD_W];
         end
      end
   end

`ifdef LINE_SCHED_TMO_EN
   localparam int unsigned TmoW = $clog2(TMO_CYC + 1);
   logic [TmoW-1:0] tmo_q, tmo_d;

   always_comb begin
      tmo_d = tmo_q;
      if (state_q == StIssue) tmo_d = '0;
      else if (state_q == StWait) tmo_d = tmo_q + TmoW'(1);
   end

   // Hit on the TMO_CYC-th cycle spent in WAIT.
   assign tmo_hit = (tmo_q == TmoW'(TMO_CYC - 1));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) tmo_q <= '0;
      else        tmo_q <= tmo_d;
   end
`else
   logic unused_tmo_cyc;
   assign unused_tmo_cyc = ^TMO_CYC;
   assign tmo_hit        = 1'b0;
`endif

   // Outputs are registered, so they are computed from the transition being taken.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      cur_d   = cur_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      x1_d    = x1_q;
      y1_d    = y1_q;
      ack_d   = '0;
      cmp_d   = '0;
      err_d   = 1'b0;
      start_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d = StIssue;
               cur_d   = pick;
               ack_d   = OneHot0 << pick;
               start_d = 1'b1;
               x0_d    = sel_x0;
               y0_d    = sel_y0;
               x1_d    = sel_x1;
               y1_d    = sel_y1;
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            if (eng_done) begin
               state_d = StRelease;
               cmp_d   = OneHot0 << cur_q;
            end else if (tmo_hit) begin
               state_d = StRelease;
               cmp_d   = OneHot0 << cur_q;
               err_d   = 1'b1;
            end
         end
         StRelease: begin
            state_d = StIdle;
            rr_d    = (cur_q == ID_W'(NREQ - 1)) ? '0 : cur_q + ID_W'(1);
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= StIdle;
         rr_q    <= '0;
         cur_q   <= '0;
         x0_q    <= '0;
         y0_q    <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         ack_q   <= '0;
         cmp_q   <= '0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         cur_q   <= cur_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         x1_q    <= x1_d;
         y1_q    <= y1_d;
         ack_q   <= ack_d;
         cmp_q   <= cmp_d;
         err_q   <= err_d;
         start_q <= start_d;
         busy_q  <= busy_d;
      end
   end

   assign ack       = ack_q;
   assign cmp       = cmp_q;
   assign cmp_err   = err_q;
   assign eng_x0    = x0_q;
   assign eng_y0    = y0_q;
   assign eng_x1    = x1_q;
   assign eng_y1    = y1_q;
   assign eng_start = start_q;
   assign busy      = busy_q;
   assign cur_id    = cur_q;

endmodule

// File: tb/tb_line_draw_scheduler.sv
// Self-checking bench for line_draw_scheduler: vector table, scoreboard queues and a
// behavioural engine; watchdog cases run when LINE_SCHED_TMO_EN is defined.
module tb_line_draw_scheduler;

   localparam int unsigned NREQ = 4;
   localparam int unsigned CW   = 8;
   localparam int unsigned TMO  = 16;

   logic clk = 1'b0;
   logic n_rst = 1'b1;
   logic [NREQ-1:0] req = '0;
   logic [NREQ*CW-1:0] req_x0 = '0, req_y0 = '0, req_x1 = '0, req_y1 = '0;
   logic [NREQ-1:0] ack, cmp;
   logic cmp_err, eng_start, busy, eng_done;
   logic [CW-1:0] eng_x0, eng_y0, eng_x1, eng_y1;
   logic [1:0] cur_id;

   logic eng_pulse = 1'b0;
   logic eng_force = 1'b0;
   int eng_delay = 0;
   int eng_cnt = 0;
   assign eng_done = eng_pulse | eng_force;

   always #5 clk = ~clk;

   line_draw_scheduler #(.NREQ(NREQ), .COORD_W(CW), .TMO_CYC(TMO)) dut (
      .clk(clk), .n_rst(n_rst), .req(req),
      .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
      .ack(ack), .cmp(cmp), .cmp_err(cmp_err),
      .eng_x0(eng_x0), .eng_y0(eng_y0), .eng_x1(eng_x1), .eng_y1(eng_y1),
      .eng_start(eng_start), .eng_done(eng_done), .busy(busy), .cur_id(cur_id)
   );

   typedef struct {int id; logic [7:0] x0, y0, x1, y1; logic err;} exp_t;
   typedef struct {logic [3:0] req; int delay; bit degen; int exp_id;} vec_t;

   exp_t ack_q[$];
   exp_t cmp_q[$];
   exp_t mon_e;
   int checks = 0, errors = 0, ack_seen = 0, cmp_seen = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return 64'({ack, cmp, cmp_err, eng_start, busy, eng_x0, eng_y0, eng_x1, eng_y1, cur_id});
   endfunction

   // Engine: done pulses eng_delay cycles after the start pulse; delay 0 never finishes.
   always @(negedge clk or negedge n_rst) begin
      if (!n_rst) begin
         eng_cnt   <= 0;
         eng_pulse <= 1'b0;
      end else begin
         if (eng_start && eng_delay > 0) eng_cnt <= eng_delay;
         else if (eng_cnt > 0)           eng_cnt <= eng_cnt - 1;
         eng_pulse <= (!eng_start && eng_cnt == 1);
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (n_rst) begin
         chk("start_eq_ack", 64'(eng_start), 64'(|ack));
         if (ack != '0) begin
            ack_seen++;
            if (ack_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL ack_unexpected: got ack=%b expected none", ack);
            end else begin
               mon_e = ack_q.pop_front();
               chk("ack_onehot", 64'(ack), 64'(1) << mon_e.id);
               chk("ack_cur_id", 64'(cur_id), 64'(mon_e.id));
               chk("ack_coords", 64'({eng_x0, eng_y0, eng_x1, eng_y1}),
                   64'({mon_e.x0, mon_e.y0, mon_e.x1, mon_e.y1}));
            end
         end
         if (cmp != '0) begin
            cmp_seen++;
            if (cmp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL cmp_unexpected: got cmp=%b expected none", cmp);
            end else begin
               mon_e = cmp_q.pop_front();
               chk("cmp_onehot", 64'(cmp), 64'(1) << mon_e.id);
               chk("cmp_err", 64'(cmp_err), 64'(mon_e.err));
            end
         end
      end
   end

   function automatic exp_t mk_exp(input int v, input int id, input bit degen, input bit err);
      exp_t e;
      e.id  = id;
      e.x0  = 8'(v * 16 + id * 4);
      e.y0  = 8'(v * 16 + id * 4 + 1);
      e.x1  = degen ? e.x0 : 8'(v * 16 + id * 4 + 2);
      e.y1  = degen ? e.y0 : 8'(v * 16 + id * 4 + 3);
      e.err = err;
      return e;
   endfunction

   task automatic set_coords(input int v, input bit degen);
      exp_t e;
      for (int i = 0; i < NREQ; i++) begin
         e = mk_exp(v, i, degen, 1'b0);
         req_x0[i*CW +: CW] = e.x0;
         req_y0[i*CW +: CW] = e.y0;
         req_x1[i*CW +: CW] = e.x1;
         req_y1[i*CW +: CW] = e.y1;
      end
   endtask

   task automatic expect_line(input int v, input int id, input bit degen, input bit err);
      ack_q.push_back(mk_exp(v, id, degen, 1'b0));
      cmp_q.push_back(mk_exp(v, id, degen, err));
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      req = '0;
      eng_force = 1'b0;
      eng_delay = 0;
      ack_q.delete();
      cmp_q.delete();
      #1;
      chk("reset_vals", outs(), 64'(0));
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
   endtask

   task automatic wait_evt(input bit want_cmp, input int limit, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (((want_cmp ? cmp : ack) == '0) && n < limit);
      if ((want_cmp ? cmp : ack) == '0) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout after %0d cycles, got none expected event", name, n);
      end
   endtask

   vec_t vecs[8];
   longint t0;
   int base_ack, base_cmp;

   initial begin
      vecs[0] = '{4'b0010, 2, 1'b0, 1};
      vecs[1] = '{4'b0011, 5, 1'b0, 0};
      vecs[2] = '{4'b1001, 1, 1'b0, 3};
      vecs[3] = '{4'b1001, 4, 1'b0, 0};
      vecs[4] = '{4'b0100, 7, 1'b0, 2};
      vecs[5] = '{4'b0111, 3, 1'b0, 0};
      vecs[6] = '{4'b1110, 1, 1'b0, 1};
      vecs[7] = '{4'b1000, 2, 1'b1, 3};

      #2;
      // Idle with stray engine-done pulses.
      do_reset();
      for (int c = 0; c < 20; c++) begin
         eng_force = (c % 3 == 0);
         @(negedge clk);
         chk("t1_idle_outs", outs(), 64'(0));
      end
      eng_force = 1'b0;

      // Single line from requester 2; coords change after ack must not leak.
      do_reset();
      eng_delay = 12;
      req_x0[2*CW +: CW] = 8'd0;
      req_y0[2*CW +: CW] = 8'd0;
      req_x1[2*CW +: CW] = 8'd10;
      req_y1[2*CW +: CW] = 8'd5;
      ack_q.push_back('{2, 8'd0, 8'd0, 8'd10, 8'd5, 1'b0});
      cmp_q.push_back('{2, 8'd0, 8'd0, 8'd10, 8'd5, 1'b0});
      t0 = $time;
      req = 4'b0100;
      wait_evt(1'b0, 10, "t2_ack_wait");
      chk("t2_ack_lat", 64'(($time - t0) / 10), 64'(1));
      t0 = $time;
      req = '0;
      req_x0[2*CW +: CW] = 8'd99;
      req_x1[2*CW +: CW] = 8'd77;
      repeat (3) @(negedge clk);
      chk("t2_hold", 64'({busy, eng_x0, eng_y0, eng_x1, eng_y1}), {31'd0, 1'b1, 32'h00000A05});
      wait_evt(1'b1, 30, "t2_cmp_wait");
      chk("t2_cmp_lat", 64'(($time - t0) / 10), 64'(13));
      @(negedge clk);
      chk("t2_busy_after", 64'({busy, cmp}), 64'(0));

      // Vector table.
      do_reset();
      for (int v = 0; v < 8; v++) begin
         set_coords(v, vecs[v].degen);
         eng_delay = vecs[v].delay;
         expect_line(v, vecs[v].exp_id, vecs[v].degen, 1'b0);
         t0 = $time;
         req = vecs[v].req;
         wait_evt(1'b0, 20, "tbl_ack_wait");
         chk("tbl_ack_lat", 64'(($time - t0) / 10), 64'(1));
         t0 = $time;
         req = '0;
         wait_evt(1'b1, 40, "tbl_cmp_wait");
         chk("tbl_cmp_lat", 64'(($time - t0) / 10), 64'(vecs[v].delay + 1));
         @(negedge clk);
         chk("tbl_idle", 64'({busy, cmp}), 64'(0));
      end

      // Fairness with all requesters held.
      do_reset();
      set_coords(10, 1'b0);
      eng_delay = 3;
      expect_line(10, 0, 1'b0, 1'b0);
      expect_line(10, 1, 1'b0, 1'b0);
      expect_line(10, 2, 1'b0, 1'b0);
      expect_line(10, 3, 1'b0, 1'b0);
      expect_line(10, 0, 1'b0, 1'b0);
      base_ack = ack_seen;
      base_cmp = cmp_seen;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) wait_evt(1'b0, 20, "t3_ack_wait");
      req = '0;
      repeat (20) @(negedge clk);
      chk("t3_ack_count", 64'(ack_seen - base_ack), 64'(5));
      chk("t3_cmp_count", 64'(cmp_seen - base_cmp), 64'(5));

      // Withdrawn request is never granted.
      do_reset();
      set_coords(11, 1'b0);
      eng_delay = 10;
      expect_line(11, 0, 1'b0, 1'b0);
      base_ack = ack_seen;
      req = 4'b0001;
      wait_evt(1'b0, 10, "t4_ack_wait");
      req = '0;
      repeat (2) @(negedge clk);
      req = 4'b0010;
      repeat (3) @(negedge clk);
      req = '0;
      wait_evt(1'b1, 20, "t4_cmp_wait");
      repeat (10) @(negedge clk);
      chk("t4_ack_count", 64'(ack_seen - base_ack), 64'(1));

      // eng_done high in IDLE and ISSUE is ignored; only the first WAIT high counts.
      do_reset();
      set_coords(12, 1'b0);
      base_cmp = cmp_seen;
      eng_force = 1'b1;
      repeat (5) @(negedge clk);
      chk("t5_idle_busy", 64'({busy, cmp}), 64'(0));
      eng_delay = 6;
      expect_line(12, 3, 1'b0, 1'b0);
      req = 4'b1000;
      wait_evt(1'b0, 10, "t5_ack_wait");
      t0 = $time;
      req = '0;
      @(negedge clk);
      eng_force = 1'b0;
      wait_evt(1'b1, 20, "t5_cmp_wait");
      chk("t5_cmp_lat", 64'(($time - t0) / 10), 64'(7));
      eng_delay = 0;
      expect_line(12, 3, 1'b0, 1'b0);
      req = 4'b1000;
      wait_evt(1'b0, 10, "t5b_ack_wait");
      t0 = $time;
      req = '0;
      repeat (2) @(negedge clk);
      eng_force = 1'b1;
      wait_evt(1'b1, 20, "t5b_cmp_wait");
      chk("t5b_cmp_lat", 64'(($time - t0) / 10), 64'(3));
      repeat (4) @(negedge clk);
      eng_force = 1'b0;
      chk("t5_cmp_count", 64'(cmp_seen - base_cmp), 64'(2));
      chk("t5_busy_end", 64'(busy), 64'(0));

      // Reset in the middle of WAIT: immediate reset values, no completion.
      do_reset();
      set_coords(13, 1'b0);
      expect_line(13, 2, 1'b0, 1'b0);
      req = 4'b0100;
      wait_evt(1'b0, 10, "t7_ack_wait");
      req = '0;
      repeat (5) @(negedge clk);
      base_cmp = cmp_seen;
      #2 n_rst = 1'b0;
      #1 chk("t7_mid_reset", outs(), 64'(0));
      cmp_q.delete();
      @(negedge clk);
      @(negedge clk);
      n_rst = 1'b1;
      repeat (10) @(negedge clk);
      chk("t7_no_cmp", 64'(cmp_seen - base_cmp), 64'(0));

`ifdef LINE_SCHED_TMO_EN
      // Watchdog abort, then eng_done on the limit cycle winning over the watchdog.
      do_reset();
      set_coords(14, 1'b0);
      expect_line(14, 1, 1'b0, 1'b1);
      req = 4'b0010;
      wait_evt(1'b0, 10, "t6_ack_wait");
      t0 = $time;
      req = '0;
      wait_evt(1'b1, 40, "t6_cmp_wait");
      chk("t6_tmo_lat", 64'(($time - t0) / 10), 64'(TMO + 1));
      @(negedge clk);
      chk("t6_after", 64'({busy, cmp_err}), 64'(0));
      eng_delay = TMO;
      expect_line(14, 1, 1'b0, 1'b0);
      req = 4'b0010;
      wait_evt(1'b0, 10, "t6b_ack_wait");
      t0 = $time;
      req = '0;
      wait_evt(1'b1, 40, "t6b_cmp_wait");
      chk("t6b_done_wins_lat", 64'(($time - t0) / 10), 64'(TMO + 1));
`endif

      repeat (3) @(negedge clk);
      chk("sb_drained", 64'(ack_q.size() + cmp_q.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule
